// File: rtl/pc_call_unit_pkg.sv
// Shared types for the program counter / call-return unit: action encoding in
// priority order plus the priority select used by the top and any decoder.
package pc_call_unit_pkg;

    typedef enum logic [2:0] {
        ACT_CLR  = 3'd0,
        ACT_RET  = 3'd1,
        ACT_CALL = 3'd2,
        ACT_LOAD = 3'd3,
        ACT_INC  = 3'd4,
        ACT_HOLD = 3'd5
    } act_e;

    // Exactly one action per cycle; earlier arguments win.
    function automatic act_e sel_action(input logic clr, input logic ret,
                                        input logic call, input logic load,
                                        input logic inc);
        act_e act;
        if (clr)       act = ACT_CLR;
        else if (ret)  act = ACT_RET;
        else if (call) act = ACT_CALL;
        else if (load) act = ACT_LOAD;
        else if (inc)  act = ACT_INC;
        else           act = ACT_HOLD;
        return act;
    endfunction

endpackage

// File: rtl/pc_call_unit_if.sv
// Control strobes in, registered pc/stack status out; master = control decoder,
// slave = pc_call_unit. No handshake: every strobe is consumed the cycle it is seen.
interface pc_call_unit_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             clr_i;
    logic             inc_i;
    logic             load_i;
    logic             call_i;
    logic             ret_i;
    logic [WIDTH-1:0] addr_i;
    logic [WIDTH-1:0] pc_o;
    logic [DW-1:0]    depth_o;
    logic             empty_o;
    logic             full_o;
    logic             wrap_o;
    logic             err_o;

    modport master (
        output clr_i, inc_i, load_i, call_i, ret_i, addr_i,
        input  pc_o, depth_o, empty_o, full_o, wrap_o, err_o
    );

    modport slave (
        input  clr_i, inc_i, load_i, call_i, ret_i, addr_i,
        output pc_o, depth_o, empty_o, full_o, wrap_o, err_o
    );
endinterface

// File: rtl/pc_call_unit_ret_stack.sv
// WIDTH x DEPTH return-address LIFO; push/pop/clear take effect at the clock edge,
// top_o is the current top entry; push on full / pop on empty are ignored.
module ret_stack #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [DW-1:0]    depth_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_depth;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_push;
    logic             w_pop;

    assign full_o   = (r_depth == DW'(DEPTH));
    assign empty_o  = (r_depth == '0);
    assign w_pop    = pop_i && !empty_o && !clr_i;
    assign w_push   = push_i && !full_o && !clr_i && !pop_i;
    assign w_wr_idx = r_depth[AW-1:0];
    // Wraps when empty; the resulting top_o is never consumed in that state.
    assign w_rd_idx = w_wr_idx - AW'(1);
    assign top_o    = r_mem[w_rd_idx];
    assign depth_o  = r_depth;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_depth <= '0;
        end else if (clr_i) begin
            r_depth <= '0;
        end else if (w_pop) begin
            r_depth <= r_depth - DW'(1);
        end else if (w_push) begin
            r_depth <= r_depth + DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= data_i;
        end
    end
endmodule

// File: rtl/pc_call_unit.sv
// Program counter with call/return stack; one prioritised action per cycle,
// all outputs registered (visible one edge after the strobe), no backpressure.
module pc_call_unit
    import pc_call_unit_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input logic           clk_i,
    input logic           rst_i,
    pc_call_unit_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);

    act_e             w_act;
    logic [WIDTH-1:0] r_pc;
    logic             r_wrap;
    logic             r_err;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_wrap_nxt;
    logic             w_err_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_clr;
    logic [WIDTH-1:0] w_top;
    logic [DW-1:0]    w_depth;
    logic             w_full;
    logic             w_empty;

    assign w_act    = sel_action(bus.clr_i, bus.ret_i, bus.call_i, bus.load_i, bus.inc_i);
    assign w_pc_inc = r_pc + WIDTH'(1);

    always_comb begin
        w_pc_nxt   = r_pc;
        w_err_nxt  = r_err;
        w_wrap_nxt = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_clr      = 1'b0;
        case (w_act)
            ACT_CLR: begin
                w_clr     = 1'b1;
                w_pc_nxt  = RESET_VEC;
                w_err_nxt = 1'b0;
            end
            ACT_RET: begin
                if (w_empty) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_pop    = 1'b1;
                    w_pc_nxt = w_top;
                end
            end
            ACT_CALL: begin
                // A refused call does nothing else, so no wrap pulse either.
                if (w_full) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_push     = 1'b1;
                    w_pc_nxt   = bus.addr_i;
                    w_wrap_nxt = &r_pc;
                end
            end
            ACT_LOAD: w_pc_nxt = bus.addr_i;
            ACT_INC: begin
                w_pc_nxt   = w_pc_inc;
                w_wrap_nxt = &r_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc   <= RESET_VEC;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_pc   <= w_pc_nxt;
            r_wrap <= w_wrap_nxt;
            r_err  <= w_err_nxt;
        end
    end

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_clr),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_pc_inc),
        .top_o   (w_top),
        .depth_o (w_depth),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign bus.pc_o    = r_pc;
    assign bus.depth_o = w_depth;
    assign bus.full_o  = w_full;
    assign bus.empty_o = w_empty;
    assign bus.wrap_o  = r_wrap;
    assign bus.err_o   = r_err;
endmodule

// File: tb/tb_pc_call_unit.sv
// Directed bench for pc_call_unit (WIDTH=16, DEPTH=4, RESET_VEC=0).
module tb_pc_call_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pc_call_unit_if #(.WIDTH(16), .DEPTH(4)) bus ();

    pc_call_unit #(
        .WIDTH     (16),
        .DEPTH     (4),
        .RESET_VEC (16'h0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of strobes, then sample 1 time unit after the edge.
    task automatic cyc(input logic clr, input logic ret, input logic call,
                       input logic load, input logic inc, input logic [15:0] addr);
        bus.clr_i  = clr;
        bus.ret_i  = ret;
        bus.call_i = call;
        bus.load_i = load;
        bus.inc_i  = inc;
        bus.addr_i = addr;
        @(posedge clk);
        #1;
        bus.clr_i  = 1'b0;
        bus.ret_i  = 1'b0;
        bus.call_i = 1'b0;
        bus.load_i = 1'b0;
        bus.inc_i  = 1'b0;
        bus.addr_i = 16'h0000;
    endtask

    initial begin
        bus.clr_i  = 1'b0;
        bus.ret_i  = 1'b0;
        bus.call_i = 1'b0;
        bus.load_i = 1'b0;
        bus.inc_i  = 1'b0;
        bus.addr_i = 16'h0000;

        #2;
        chk("rst_pc",    32'(bus.pc_o),    32'h0);
        chk("rst_depth", 32'(bus.depth_o), 32'h0);
        chk("rst_empty", 32'(bus.empty_o), 32'h1);
        chk("rst_full",  32'(bus.full_o),  32'h0);
        chk("rst_wrap",  32'(bus.wrap_o),  32'h0);
        chk("rst_err",   32'(bus.err_o),   32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cyc(0, 0, 0, 0, 1, 16'h0); chk("inc1", 32'(bus.pc_o), 32'h1);
        cyc(0, 0, 0, 0, 1, 16'h0); chk("inc2", 32'(bus.pc_o), 32'h2);
        cyc(0, 0, 0, 0, 1, 16'h0); chk("inc3", 32'(bus.pc_o), 32'h3);
        chk("inc3_wrap", 32'(bus.wrap_o), 32'h0);

        cyc(0, 0, 0, 1, 0, 16'hFFFF); chk("load_ffff", 32'(bus.pc_o), 32'hFFFF);
        cyc(0, 0, 0, 0, 1, 16'h0);
        chk("inc_wrap_pc",   32'(bus.pc_o),   32'h0);
        chk("inc_wrap_flag", 32'(bus.wrap_o), 32'h1);
        cyc(0, 0, 0, 0, 0, 16'h0);
        chk("wrap_one_cycle", 32'(bus.wrap_o), 32'h0);
        chk("hold_pc",        32'(bus.pc_o),   32'h0);

        cyc(0, 0, 0, 1, 1, 16'h0777); chk("load_beats_inc", 32'(bus.pc_o), 32'h0777);

        cyc(0, 0, 0, 1, 0, 16'h0010);
        cyc(0, 0, 1, 0, 0, 16'h0100);
        chk("call1_pc", 32'(bus.pc_o), 32'h0100); chk("call1_depth", 32'(bus.depth_o), 32'h1);
        cyc(0, 0, 1, 0, 0, 16'h0200);
        chk("call2_pc", 32'(bus.pc_o), 32'h0200); chk("call2_depth", 32'(bus.depth_o), 32'h2);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("ret1_pc", 32'(bus.pc_o), 32'h0101); chk("ret1_depth", 32'(bus.depth_o), 32'h1);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("ret2_pc", 32'(bus.pc_o), 32'h0011); chk("ret2_depth", 32'(bus.depth_o), 32'h0);
        chk("ret2_empty", 32'(bus.empty_o), 32'h1);

        cyc(0, 0, 1, 0, 0, 16'h1000);
        cyc(0, 0, 1, 0, 0, 16'h2000);
        cyc(0, 0, 1, 0, 0, 16'h3000);
        chk("call3_full", 32'(bus.full_o), 32'h0);
        cyc(0, 0, 1, 0, 0, 16'h4000);
        chk("call4_pc",    32'(bus.pc_o),    32'h4000);
        chk("call4_depth", 32'(bus.depth_o), 32'h4);
        chk("call4_full",  32'(bus.full_o),  32'h1);
        chk("call4_err",   32'(bus.err_o),   32'h0);
        cyc(0, 0, 1, 1, 1, 16'h0AAA);
        chk("ovf_pc",    32'(bus.pc_o),    32'h4000);
        chk("ovf_err",   32'(bus.err_o),   32'h1);
        chk("ovf_depth", 32'(bus.depth_o), 32'h4);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("ret_after_err_pc",  32'(bus.pc_o),    32'h3001);
        chk("ret_after_err_dep", 32'(bus.depth_o), 32'h3);
        chk("err_sticky",        32'(bus.err_o),   32'h1);

        // Asynchronous reset between clock edges.
        #1 rst = 1'b1;
        #1;
        chk("arst_pc",    32'(bus.pc_o),    32'h0);
        chk("arst_depth", 32'(bus.depth_o), 32'h0);
        chk("arst_empty", 32'(bus.empty_o), 32'h1);
        chk("arst_err",   32'(bus.err_o),   32'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        cyc(0, 0, 0, 1, 0, 16'h0055);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("ret_empty_pc",  32'(bus.pc_o),  32'h0055);
        chk("ret_empty_err", 32'(bus.err_o), 32'h1);
        cyc(0, 0, 0, 0, 1, 16'h0);
        chk("err_no_block", 32'(bus.pc_o), 32'h0056);
        cyc(1, 0, 0, 0, 0, 16'h0);
        chk("clr_pc",  32'(bus.pc_o),  32'h0);
        chk("clr_err", 32'(bus.err_o), 32'h0);

        cyc(0, 0, 0, 1, 0, 16'hFFFF);
        cyc(0, 0, 1, 0, 0, 16'h0300);
        chk("call_wrap_pc",    32'(bus.pc_o),    32'h0300);
        chk("call_wrap_flag",  32'(bus.wrap_o),  32'h1);
        chk("call_wrap_depth", 32'(bus.depth_o), 32'h1);
        cyc(0, 1, 1, 0, 1, 16'h0999);
        chk("ret_wins_pc",    32'(bus.pc_o),    32'h0);
        chk("ret_wins_depth", 32'(bus.depth_o), 32'h0);
        chk("ret_wins_err",   32'(bus.err_o),   32'h0);
        chk("ret_wins_wrap",  32'(bus.wrap_o),  32'h0);

        cyc(0, 0, 0, 1, 0, 16'h1234);
        cyc(0, 0, 1, 0, 0, 16'h0042);
        cyc(0, 1, 0, 0, 1, 16'h0);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("pre_clr_err", 32'(bus.err_o), 32'h1);
        cyc(0, 0, 1, 0, 0, 16'h0042);
        cyc(1, 1, 1, 1, 1, 16'h5555);
        chk("all_clr_pc",    32'(bus.pc_o),    32'h0);
        chk("all_clr_depth", 32'(bus.depth_o), 32'h0);
        chk("all_clr_empty", 32'(bus.empty_o), 32'h1);
        chk("all_clr_err",   32'(bus.err_o),   32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
